// File: rtl/dds_phase_gen.sv
// dds_phase_gen: DDS phase accumulator with a serial shift-add tuning-word converter.
module dds_phase_gen #(
  parameter logic [13:0] K_SCALE    = 14'd10995,
  parameter int unsigned RESET_FREQ = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] freq_in,
  input  logic        en,
  input  logic        phase_clr,
  output logic [11:0] phase_out,
  output logic        wrap,
  output logic [31:0] tuning_word,
  output logic        busy,
  output logic        tw_update
);
  typedef enum logic [1:0] {IDLE, CALC, LOAD} state_t;
  localparam logic [33:0] RESET_PROD = 34'(RESET_FREQ) * 34'(K_SCALE);
  localparam logic [31:0] RESET_TW   = 32'(RESET_PROD >> 8);
  state_t      state_q, state_d;
  logic [19:0] freq_q, freq_d;
  logic [33:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] tw_q, tw_d;
  logic [31:0] phase_q;
  logic        wrap_q;
  logic        start;
  logic [32:0] sum;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      freq_q  <= 20'(RESET_FREQ);
      acc_q   <= '0;
      cnt_q   <= '0;
      tw_q    <= RESET_TW;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tw_q    <= tw_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE) ? ((freq_in != freq_q) ? CALC : IDLE) :
              (state_q == CALC) ? ((cnt_q == 5'd19) ? LOAD : CALC) : IDLE;
  end
  // One multiplier bit per CALC cycle, LSB first
  always_comb begin
    start = (state_q == IDLE) && (freq_in != freq_q);
    freq_d = start ? freq_in : freq_q;
    acc_d = start ? '0 :
            ((state_q == CALC) && freq_q[cnt_q]) ? acc_q + (34'(K_SCALE) << cnt_q) : acc_q;
    cnt_d = start ? '0 : (state_q == CALC) ? cnt_q + 5'd1 : cnt_q;
    tw_d = (state_q == LOAD) ? 32'(acc_q >> 8) : tw_q;
  end
  always_comb begin
    busy      = state_q != IDLE;
    tw_update = state_q == LOAD;
  end
  assign sum = {1'b0, phase_q} + {1'b0, tw_q};
  always_ff @(posedge clk) begin
    if (rst || phase_clr) begin
      phase_q <= '0;
      wrap_q  <= 1'b0;
    end else if (en) begin
      phase_q <= sum[31:0];
      wrap_q  <= sum[32];
    end else begin
      wrap_q  <= 1'b0;
    end
  end
  assign phase_out   = phase_q[31:20];
  assign wrap        = wrap_q;
  assign tuning_word = tw_q;
endmodule
